servo_pulse_decoder: RTL and testbench
======================================

# servo_pulse_decoder

Receive-side counterpart to the servo lock PWM generator. It measures the high time of a 50 Hz servo control pulse train, sampled at 25 MHz, and reports each measured width. It classifies the width as the latch "open" (about 2.48 ms) or "closed" (about 0.68 ms) position. It flags out-of-window pulses and loss of the pulse train. It sits on a loopback or feedback input, so the passcode logic can confirm the commanded latch position is actually being driven.

## Interface
- OPEN_WIDTH, 62000: nominal open-position high time, in clock cycles.
- CLOSED_WIDTH, 17000: nominal closed-position high time, in clock cycles.
- TOLERANCE, 1000: allowed absolute deviation from a nominal width, in cycles (inclusive).
- FRAME_TIMEOUT, 600000: cycles without a rising edge before a loss-of-signal fault.
- i_Clk  in  1  system clock, 25 MHz. Everything is on its rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_Servo_Pwm  in  1  asynchronous servo PWM input.
- o_Pulse_Width  out  20  last completed pulse width in cycles. Holds until the next measurement.
- o_Valid  out  1  one-cycle strobe when o_Pulse_Width updates.
- o_Open  out  1  last pulse is within OPEN_WIDTH ± TOLERANCE.
- o_Closed  out  1  last pulse is within CLOSED_WIDTH ± TOLERANCE.
- o_Fault  out  1  last pulse was out of both windows, or a timeout occurred.

## Operation
- **Input conditioning:** 2-flop synchronizer, then one history register for edge detection. Rise = sync high and history low. Fall = sync low and history high.
- **States:**
  - S_ARM: the reset state. Go to S_WAIT_RISE on the first cycle the synced input is low. This discards any pulse that was already in progress at reset.
  - S_WAIT_RISE: on rise, load width_cnt = 1 and go to S_HIGH.
  - S_HIGH: each cycle the synced input is high, width_cnt increments, saturating at 2^20−1. On fall, latch width_cnt into o_Pulse_Width, pulse o_Valid, update the classification, and go to S_WAIT_RISE.
- **Classification on each latch:**
  - Compare using unsigned 20-bit absolute difference, with no wrap.
  - o_Open = |w − OPEN_WIDTH| ≤ TOLERANCE.
  - o_Closed = |w − CLOSED_WIDTH| ≤ TOLERANCE.
  - o_Fault = neither window matched.
  - If the windows overlap (misparameterised), o_Open wins and o_Closed is 0.
- **Timeout:**
  - gap_cnt clears on reset and on every rise. Otherwise it increments, saturating.
  - gap_cnt counts in every state, including S_HIGH. A stuck-high input therefore also times out.
  - When gap_cnt reaches FRAME_TIMEOUT: o_Fault = 1 and o_Open = o_Closed = 0. o_Pulse_Width holds and no o_Valid is issued.
  - The timeout fault persists until the next latch, which reclassifies from that pulse.
- **Saturated width:** a saturated width is still latched at the next fall and classified normally, so it always faults.
- **Reset mid-operation:** all state and outputs clear and the FSM returns to S_ARM. A pulse already high at reset produces no o_Valid.

## Timing
- Reset values: o_Pulse_Width = 0, o_Valid = 0, o_Open = 0, o_Closed = 0, o_Fault = 0. The FSM is in S_ARM with width_cnt = 0 and gap_cnt = 0.
- A pulse sampled high on exactly N consecutive i_Clk edges yields o_Pulse_Width = N.
- o_Valid rises 3 cycles after the first edge at which i_Servo_Pwm is sampled low. It is high for exactly 1 cycle.
- o_Pulse_Width, o_Open, o_Closed and o_Fault update in the same cycle that o_Valid is high.
- The timeout fault asserts on the cycle gap_cnt reaches FRAME_TIMEOUT, which is FRAME_TIMEOUT cycles after the last rise detect.
- A rise and a timeout in the same cycle: the rise takes precedence, gap_cnt clears and no fault is raised.
- Minimum measurable pulse: 1 cycle high and 1 cycle low. Back-to-back pulses each produce their own o_Valid.

## Test plan
- **Open frames:** reset, then repeat 62000 high / 438000 low. Required: o_Valid once per frame, o_Pulse_Width = 62000, o_Open = 1, o_Closed = 0, o_Fault = 0.
- **Closed frames:** repeat 17000 high / 483000 low. Required: o_Pulse_Width = 17000, o_Closed = 1, o_Open = 0, o_Fault = 0.
- **Window boundaries:**
  - Widths 61000, 63000 and 16000 → in-window, with the matching flag set.
  - Widths 63001 and 18001 → o_Open = o_Closed = 0 and o_Fault = 1.
  - A following 62500 pulse → o_Open = 1 and o_Fault clears.
- **Loss of signal:** after valid open frames, hold the input low. Required: o_Fault = 1 exactly 600000 cycles after the last rise detect, o_Open = 0, o_Pulse_Width unchanged, no o_Valid. Repeat with the input held high; the same fault is required.
- **Reset mid-pulse:** assert i_Rst for 1 cycle 20000 cycles into a high pulse, keep the input high a further 30000 cycles, then drop it. Required: all outputs 0 and no o_Valid. The next 17000-cycle pulse then reports 17000 with o_Closed = 1.
- **Minimum pulse and latency:** a 1-cycle high pulse gives o_Pulse_Width = 1 and o_Fault = 1. o_Valid is checked at exactly 3 cycles after the first low sample.

Source files
------------

// File: rtl/servo_pulse_decoder.sv
// Servo PWM receive decoder: measures each high pulse width, classifies it as
// latch open/closed, and flags out-of-window pulses or loss of the pulse train.
module servo_pulse_decoder #(
   parameter int OPEN_WIDTH    = 62000,
   parameter int CLOSED_WIDTH  = 17000,
   parameter int TOLERANCE     = 1000,
   parameter int FRAME_TIMEOUT = 600000
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic        i_Servo_Pwm,
   output logic [19:0] o_Pulse_Width,
   output logic        o_Valid,
   output logic        o_Open,
   output logic        o_Closed,
   output logic        o_Fault
);

   localparam logic [19:0] OPEN_W     = 20'(OPEN_WIDTH);
   localparam logic [19:0] CLOSED_W   = 20'(CLOSED_WIDTH);
   localparam logic [19:0] TOL_W      = 20'(TOLERANCE);
   localparam logic [19:0] TIMEOUT_M1 = 20'(FRAME_TIMEOUT - 1);
   localparam logic [19:0] CNT_MAX    = 20'hFFFFF;

   localparam logic [1:0] S_ARM       = 2'd0;
   localparam logic [1:0] S_WAIT_RISE = 2'd1;
   localparam logic [1:0] S_HIGH      = 2'd2;

   logic        sync1_r;
   logic        sync2_r;
   logic        hist_r;
   logic        rise_r;
   logic        fall_r;
   logic [1:0]  state_r;
   logic [19:0] width_cnt_r;
   logic [19:0] gap_cnt_r;
   logic        latch_s;
   logic        timeout_s;
   logic        open_hit_s;
   logic        closed_hit_s;

   function automatic logic [19:0] abs_diff(input logic [19:0] a, input logic [19:0] b);
      if (a >= b) begin
         return a - b;
      end else begin
         return b - a;
      end
   endfunction

   // Input synchronizer and history; left unreset so a pulse already high at reset stays high
   always_ff @(posedge i_Clk) begin
      sync1_r <= i_Servo_Pwm;
      sync2_r <= sync1_r;
      hist_r  <= sync2_r;
   end

   // Registered rise/fall strobes from the synchronized input
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end else begin
         rise_r <= sync2_r & ~hist_r;
         fall_r <= ~sync2_r & hist_r;
      end
   end

   // Latch/timeout qualifiers and window classification of the running width
   always_comb begin
      latch_s      = (state_r == S_HIGH) && fall_r;
      timeout_s    = !rise_r && (gap_cnt_r == TIMEOUT_M1);
      open_hit_s   = (abs_diff(width_cnt_r, OPEN_W) <= TOL_W);
      closed_hit_s = !open_hit_s && (abs_diff(width_cnt_r, CLOSED_W) <= TOL_W);
   end

   // Measurement FSM and saturating width counter
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_r     <= S_ARM;
         width_cnt_r <= 20'd0;
      end else begin
         case (state_r)
            S_ARM: begin
               width_cnt_r <= width_cnt_r;
               if (!sync2_r) begin
                  state_r <= S_WAIT_RISE;
               end else begin
                  state_r <= S_ARM;
               end
            end
            S_WAIT_RISE: begin
               if (rise_r) begin
                  width_cnt_r <= 20'd1;
                  state_r     <= S_HIGH;
               end else begin
                  width_cnt_r <= width_cnt_r;
                  state_r     <= S_WAIT_RISE;
               end
            end
            S_HIGH: begin
               if (fall_r) begin
                  width_cnt_r <= width_cnt_r;
                  state_r     <= S_WAIT_RISE;
               end else if (width_cnt_r != CNT_MAX) begin
                  width_cnt_r <= width_cnt_r + 20'd1;
                  state_r     <= S_HIGH;
               end else begin
                  width_cnt_r <= width_cnt_r;
                  state_r     <= S_HIGH;
               end
            end
            default: begin
               width_cnt_r <= 20'd0;
               state_r     <= S_ARM;
            end
         endcase
      end
   end

   // Gap counter runs in every state so a stuck-high input also times out
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         gap_cnt_r <= 20'd0;
      end else if (rise_r) begin
         gap_cnt_r <= 20'd0;
      end else if (gap_cnt_r != CNT_MAX) begin
         gap_cnt_r <= gap_cnt_r + 20'd1;
      end else begin
         gap_cnt_r <= gap_cnt_r;
      end
   end

   // Output registers: a completed pulse reclassifies, a timeout forces the fault
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         o_Pulse_Width <= 20'd0;
         o_Valid       <= 1'b0;
         o_Open        <= 1'b0;
         o_Closed      <= 1'b0;
         o_Fault       <= 1'b0;
      end else if (latch_s) begin
         o_Pulse_Width <= width_cnt_r;
         o_Valid       <= 1'b1;
         o_Open        <= open_hit_s;
         o_Closed      <= closed_hit_s;
         o_Fault       <= !open_hit_s && !closed_hit_s;
      end else if (timeout_s) begin
         o_Pulse_Width <= o_Pulse_Width;
         o_Valid       <= 1'b0;
         o_Open        <= 1'b0;
         o_Closed      <= 1'b0;
         o_Fault       <= 1'b1;
      end else begin
         o_Pulse_Width <= o_Pulse_Width;
         o_Valid       <= 1'b0;
         o_Open        <= o_Open;
         o_Closed      <= o_Closed;
         o_Fault       <= o_Fault;
      end
   end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed bench for servo_pulse_decoder, run with widths and timeout scaled
// down by 100 so every scenario fits in a short simulation.
module tb_servo_pulse_decoder;

   localparam int OPEN_W  = 620;
   localparam int CLOSE_W = 170;
   localparam int TOL     = 10;
   localparam int FT      = 6000;

   logic        clk = 1'b0;
   logic        rst;
   logic        pwm;
   logic [19:0] width;
   logic        valid;
   logic        open_f;
   logic        closed_f;
   logic        fault;

   int checks    = 0;
   int failures  = 0;
   int valid_cnt = 0;
   int v0        = 0;

   servo_pulse_decoder #(
      .OPEN_WIDTH   (OPEN_W),
      .CLOSED_WIDTH (CLOSE_W),
      .TOLERANCE    (TOL),
      .FRAME_TIMEOUT(FT)
   ) dut (
      .i_Clk        (clk),
      .i_Rst        (rst),
      .i_Servo_Pwm  (pwm),
      .o_Pulse_Width(width),
      .o_Valid      (valid),
      .o_Open       (open_f),
      .o_Closed     (closed_f),
      .o_Fault      (fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (valid === 1'b1) valid_cnt <= valid_cnt + 1;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input int hi, input int lo);
      pwm = 1'b1;
      cyc(hi);
      pwm = 1'b0;
      cyc(lo);
   endtask

   task automatic chk_out(input string tag, input int w, input logic o, input logic c, input logic f);
      chk({tag, "_width"},  32'(width),    32'(w));
      chk({tag, "_open"},   32'(open_f),   32'(o));
      chk({tag, "_closed"}, 32'(closed_f), 32'(c));
      chk({tag, "_fault"},  32'(fault),    32'(f));
   endtask

   initial begin
      rst = 1'b1;
      pwm = 1'b0;
      cyc(5);
      chk_out("reset", 0, 1'b0, 1'b0, 1'b0);
      chk("reset_valid", 32'(valid), 32'd0);
      rst = 1'b0;
      cyc(2);

      // nominal open and closed frames
      for (int i = 0; i < 2; i++) begin
         v0 = valid_cnt;
         send(OPEN_W, 4380);
         chk_out("open_frame", OPEN_W, 1'b1, 1'b0, 1'b0);
         chk("open_frame_vcnt", 32'(valid_cnt), 32'(v0 + 1));
      end
      for (int i = 0; i < 2; i++) begin
         v0 = valid_cnt;
         send(CLOSE_W, 4830);
         chk_out("closed_frame", CLOSE_W, 1'b0, 1'b1, 1'b0);
         chk("closed_frame_vcnt", 32'(valid_cnt), 32'(v0 + 1));
      end

      // window boundaries (tolerance is inclusive)
      send(610, 200); chk_out("bnd_610", 610, 1'b1, 1'b0, 1'b0);
      send(630, 200); chk_out("bnd_630", 630, 1'b1, 1'b0, 1'b0);
      send(160, 200); chk_out("bnd_160", 160, 1'b0, 1'b1, 1'b0);
      send(180, 200); chk_out("bnd_180", 180, 1'b0, 1'b1, 1'b0);
      send(631, 200); chk_out("bnd_631", 631, 1'b0, 1'b0, 1'b1);
      send(181, 200); chk_out("bnd_181", 181, 1'b0, 1'b0, 1'b1);
      send(625, 200); chk_out("bnd_625", 625, 1'b1, 1'b0, 1'b0);

      // loss of signal, input held low: rise strobe reaches the counter 3 edges after the first high sample
      v0 = valid_cnt;
      pwm = 1'b1;
      cyc(OPEN_W);
      pwm = 1'b0;
      cyc(FT + 3 - OPEN_W);
      chk_out("los_low_before", OPEN_W, 1'b1, 1'b0, 1'b0);
      cyc(1);
      chk_out("los_low_at", OPEN_W, 1'b0, 1'b0, 1'b1);
      chk("los_low_vcnt", 32'(valid_cnt), 32'(v0 + 1));

      // a good pulse clears the timeout fault
      send(OPEN_W, 4380);
      chk_out("los_recover", OPEN_W, 1'b1, 1'b0, 1'b0);

      // loss of signal, input held high
      v0 = valid_cnt;
      pwm = 1'b1;
      cyc(FT + 3);
      chk_out("los_high_before", OPEN_W, 1'b1, 1'b0, 1'b0);
      cyc(1);
      chk_out("los_high_at", OPEN_W, 1'b0, 1'b0, 1'b1);
      chk("los_high_vcnt", 32'(valid_cnt), 32'(v0));
      pwm = 1'b0;
      cyc(10);
      chk_out("stuck_release", FT + 4, 1'b0, 1'b0, 1'b1);
      chk("stuck_release_vcnt", 32'(valid_cnt), 32'(v0 + 1));

      // reset in the middle of a high pulse
      pwm = 1'b1;
      cyc(200);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      v0 = valid_cnt;
      chk_out("midrst", 0, 1'b0, 1'b0, 1'b0);
      cyc(300);
      pwm = 1'b0;
      cyc(20);
      chk_out("midrst_drop", 0, 1'b0, 1'b0, 1'b0);
      chk("midrst_vcnt", 32'(valid_cnt), 32'(v0));
      send(CLOSE_W, 200);
      chk_out("midrst_next", CLOSE_W, 1'b0, 1'b1, 1'b0);
      chk("midrst_next_vcnt", 32'(valid_cnt), 32'(v0 + 1));

      // minimum pulse: o_Valid exactly 3 edges after the first low sample
      pwm = 1'b1;
      cyc(1);
      pwm = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         cyc(1);
         chk("min_valid_step", 32'(valid), (i == 4) ? 32'd1 : 32'd0);
         if (i == 4) chk_out("min_pulse", 1, 1'b0, 1'b0, 1'b1);
      end

      // back-to-back minimum pulses each strobe once
      v0 = valid_cnt;
      send(1, 1);
      send(1, 10);
      chk("b2b_vcnt", 32'(valid_cnt), 32'(v0 + 2));
      chk_out("b2b", 1, 1'b0, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
